// File: rtl/fp32_multiplier_if.sv
// Start/done handshake bundle between the FP unit sequencer and the
// single-precision multiplier. The sequencer owns the request side (master),
// the multiplier owns the result side (slave).
interface fp32_multiplier_if;
   logic        mul_start;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] mul_result;
   logic        mul_done;
   logic        mul_overflow;

   modport master (
      output mul_start,
      output op1,
      output op2,
      input  mul_result,
      input  mul_done,
      input  mul_overflow
   );

   modport slave (
      input  mul_start,
      input  op1,
      input  op2,
      output mul_result,
      output mul_done,
      output mul_overflow
   );
endinterface

// File: rtl/fp32_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier.
// A start pulse in IDLE captures both operands; the product walks through
// MULT -> NORM -> ROUND -> DONE, one state per clock. The result and the
// overflow flag are written in ROUND and held until the next completion;
// mul_done strobes for the single DONE cycle. Denormal inputs are treated as
// zero, and results below the normal range flush to signed zero.
module fp32_multiplier (
   input  logic              clk,
   input  logic              n_rst,
   fp32_multiplier_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      NORM,
      ROUND,
      DONE
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t             state;

   // Captured operands (sign bits are folded into sign_q at capture)
   logic [30:0]        a_q;
   logic [30:0]        b_q;
   logic               sign_q;

   // Datapath pipeline registers reused across the FSM states
   logic [47:0]        prod_q;
   logic signed [9:0]  exp_q;
   logic [23:0]        mant_q;
   logic               guard_q;
   logic               round_q;
   logic               sticky_q;
   logic               special_q;
   logic [31:0]        special_val_q;

   // Registered outputs
   logic [31:0]        result_q;
   logic               done_q;
   logic               ovf_q;

   // Operand field decode
   logic [7:0]         exp_a;
   logic [7:0]         exp_b;
   logic [22:0]        frac_a;
   logic [22:0]        frac_b;
   logic               a_nan;
   logic               b_nan;
   logic               a_inf;
   logic               b_inf;
   logic               a_zero;
   logic               b_zero;

   // MULT-stage combinational results
   logic [47:0]        product_c;
   logic signed [9:0]  exp_sum_c;
   logic               special_c;
   logic [31:0]        special_val_c;

   // NORM-stage combinational results
   logic [23:0]        norm_mant_c;
   logic signed [9:0]  norm_exp_c;
   logic               norm_guard_c;
   logic               norm_round_c;
   logic               norm_sticky_c;

   // ROUND-stage combinational results
   logic               round_up_c;
   logic [24:0]        rounded_c;
   logic [22:0]        final_frac_c;
   logic signed [9:0]  final_exp_c;
   logic [31:0]        result_c;
   logic               ovf_c;

   assign exp_a  = a_q[30:23];
   assign exp_b  = b_q[30:23];
   assign frac_a = a_q[22:0];
   assign frac_b = b_q[22:0];

   assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
   assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
   assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
   assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
   assign a_zero = (exp_a == 8'h00);
   assign b_zero = (exp_b == 8'h00);

   // Significand product, unbiased-exponent sum and special-operand bypass
   always_comb begin
      product_c     = {24'd0, 1'b1, frac_a} * {24'd0, 1'b1, frac_b};
      exp_sum_c     = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
      special_c     = 1'b0;
      special_val_c = 32'd0;
      if (a_nan || b_nan) begin
         special_c     = 1'b1;
         special_val_c = QNAN;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         special_c     = 1'b1;
         special_val_c = QNAN;
      end else if (a_inf || b_inf) begin
         special_c     = 1'b1;
         special_val_c = {sign_q, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         special_c     = 1'b1;
         special_val_c = {sign_q, 31'd0};
      end
   end

   // Bring the product into [1,2) and split off guard/round/sticky
   always_comb begin
      if (prod_q[47]) begin
         norm_mant_c   = prod_q[47:24];
         norm_guard_c  = prod_q[23];
         norm_round_c  = prod_q[22];
         norm_sticky_c = |prod_q[21:0];
         norm_exp_c    = exp_q + 10'sd1;
      end else begin
         norm_mant_c   = prod_q[46:23];
         norm_guard_c  = prod_q[22];
         norm_round_c  = prod_q[21];
         norm_sticky_c = |prod_q[20:0];
         norm_exp_c    = exp_q;
      end
   end

   // Round to nearest even, renormalise on carry-out, then range-check
   always_comb begin
      round_up_c = guard_q & (round_q | sticky_q | mant_q[0]);
      rounded_c  = {1'b0, mant_q} + {24'd0, round_up_c};
      if (rounded_c[24]) begin
         final_frac_c = rounded_c[23:1];
         final_exp_c  = exp_q + 10'sd1;
      end else begin
         final_frac_c = rounded_c[22:0];
         final_exp_c  = exp_q;
      end

      ovf_c    = 1'b0;
      result_c = {sign_q, final_exp_c[7:0], final_frac_c};
      if (special_q) begin
         result_c = special_val_q;
      end else if (final_exp_c >= 10'sd255) begin
         result_c = {sign_q, 8'hFF, 23'd0};
         ovf_c    = 1'b1;
      end else if (final_exp_c <= 10'sd0) begin
         result_c = {sign_q, 31'd0};
      end
   end

   // Sequencing FSM with registered result, overflow and done strobe
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state         <= IDLE;
         a_q           <= 31'd0;
         b_q           <= 31'd0;
         sign_q        <= 1'b0;
         prod_q        <= 48'd0;
         exp_q         <= 10'sd0;
         mant_q        <= 24'd0;
         guard_q       <= 1'b0;
         round_q       <= 1'b0;
         sticky_q      <= 1'b0;
         special_q     <= 1'b0;
         special_val_q <= 32'd0;
         result_q      <= 32'd0;
         done_q        <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.mul_start) begin
                  a_q    <= bus.op1[30:0];
                  b_q    <= bus.op2[30:0];
                  sign_q <= bus.op1[31] ^ bus.op2[31];
                  state  <= MULT;
               end
            end
            MULT: begin
               prod_q        <= product_c;
               exp_q         <= exp_sum_c;
               special_q     <= special_c;
               special_val_q <= special_val_c;
               state         <= NORM;
            end
            NORM: begin
               mant_q   <= norm_mant_c;
               exp_q    <= norm_exp_c;
               guard_q  <= norm_guard_c;
               round_q  <= norm_round_c;
               sticky_q <= norm_sticky_c;
               state    <= ROUND;
            end
            ROUND: begin
               result_q <= result_c;
               ovf_q    <= ovf_c;
               done_q   <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.mul_result   = result_q;
   assign bus.mul_done     = done_q;
   assign bus.mul_overflow = ovf_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Self-checking bench for fp32_multiplier: directed corner operands plus a
// randomized sweep, each product compared against an exact integer model of
// IEEE-754 single multiplication (round to nearest even, flush-to-zero).
module tb_fp32_multiplier;

   logic clk;
   logic n_rst;

   int   assert_count;
   int   fail_count;

   fp32_multiplier_if bus ();

   fp32_multiplier dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   // Exact reference: integer significand product, remainder-based rounding
   function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                          output logic ovf);
      logic            sign;
      int              ea;
      int              eb;
      int              e;
      int              shift;
      longint unsigned ma;
      longint unsigned mb;
      longint unsigned p;
      longint unsigned q;
      longint unsigned rem;
      longint unsigned half;
      bit              a_nan;
      bit              b_nan;
      bit              a_inf;
      bit              b_inf;
      bit              a_zero;
      bit              b_zero;

      sign   = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      ovf    = 1'b0;

      if (a_nan || b_nan)                        return 32'h7FC0_0000;
      if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
      if (a_inf || b_inf)                        return {sign, 8'hFF, 23'd0};
      if (a_zero || b_zero)                      return {sign, 31'd0};

      ma = 64'h80_0000 + 64'(a[22:0]);
      mb = 64'h80_0000 + 64'(b[22:0]);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
         shift = 24;
         e     = e + 1;
      end else begin
         shift = 23;
      end
      q    = p >> shift;
      rem  = p - (q << shift);
      half = 64'd1 << (shift - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) begin
         ovf = 1'b1;
         return {sign, 8'hFF, 23'd0};
      end
      if (e <= 0) return {sign, 31'd0};
      return {sign, e[7:0], q[22:0]};
   endfunction

   // One full transaction: start, scramble inputs, optionally poke start while
   // busy, then check latency, result, overflow, strobe width and hold
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input bit poke_busy);
      logic [31:0] exp_res;
      logic        exp_ovf;
      int          lat;
      bit          seen;

      exp_res = refMul(a, b, exp_ovf);
      @(negedge clk);
      bus.op1       = a;
      bus.op2       = b;
      bus.mul_start = 1'b1;
      @(posedge clk);
      #1;
      bus.mul_start = 1'b0;
      bus.op1       = $urandom;
      bus.op2       = $urandom;
      lat  = 0;
      seen = 1'b0;
      while ((lat < 10) && !seen) begin
         @(posedge clk);
         #1;
         lat++;
         if (poke_busy) bus.mul_start = (lat == 1);
         if (bus.mul_done) seen = 1'b1;
      end
      bus.mul_start = 1'b0;
      checkOutput("latency", 32'(lat), 32'd3);
      checkOutput("result", bus.mul_result, exp_res);
      checkOutput("overflow", {31'd0, bus.mul_overflow}, {31'd0, exp_ovf});
      @(posedge clk);
      #1;
      checkOutput("done_width", {31'd0, bus.mul_done}, 32'd0);
      checkOutput("result_hold", bus.mul_result, exp_res);
   endtask

   // Random operand with a chosen exponent regime to reach overflow,
   // underflow, ordinary and special-value cases
   function automatic logic [31:0] randOperand();
      logic [31:0] r;
      logic [7:0]  e;
      int          mode;
      mode = $urandom_range(0, 5);
      r    = $urandom;
      case (mode)
         0: e = r[30:23];
         1, 2: e = 8'($urandom_range(90, 164));
         3: e = 8'($urandom_range(190, 254));
         4: e = 8'($urandom_range(1, 64));
         default: e = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      endcase
      if ((mode == 5) && ($urandom_range(0, 1) == 0)) r[22:0] = 23'd0;
      return {r[31], e, r[22:0]};
   endfunction

   logic [31:0] dir_a [10];
   logic [31:0] dir_b [10];

   initial begin
      int dones;

      assert_count  = 0;
      fail_count    = 0;
      n_rst         = 1'b1;
      bus.mul_start = 1'b0;
      bus.op1       = 32'd0;
      bus.op2       = 32'd0;

      dir_a = '{32'h3FA00000, 32'h40000000, 32'h3F800000, 32'hC0400000, 32'h7F000000,
                32'h7F800000, 32'h3F800001, 32'h00800000, 32'hFF800000, 32'h7FC12345};
      dir_b = '{32'h3FC00000, 32'h40400000, 32'hC0C00000, 32'hC0800000, 32'h7F000000,
                32'h00000000, 32'h3F800001, 32'h00800000, 32'h40000000, 32'h3F800000};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_result", bus.mul_result, 32'd0);
      checkOutput("reset_done", {31'd0, bus.mul_done}, 32'd0);
      checkOutput("reset_overflow", {31'd0, bus.mul_overflow}, 32'd0);
      @(negedge clk);
      n_rst = 1'b0;

      for (int i = 0; i < 10; i++) applyStimulus(dir_a[i], dir_b[i], (i % 3) == 1);

      // Leave a held overflow result, then reset in the middle of a new op
      applyStimulus(32'h7F000000, 32'h7F000000, 1'b0);
      @(negedge clk);
      bus.op1       = 32'h40000000;
      bus.op2       = 32'h40400000;
      bus.mul_start = 1'b1;
      @(posedge clk);
      #1;
      bus.mul_start = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_result", bus.mul_result, 32'd0);
      checkOutput("midreset_done", {31'd0, bus.mul_done}, 32'd0);
      checkOutput("midreset_overflow", {31'd0, bus.mul_overflow}, 32'd0);
      @(negedge clk);
      n_rst = 1'b0;
      dones = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.mul_done) dones++;
      end
      checkOutput("midreset_no_done", 32'(dones), 32'd0);

      for (int i = 0; i < 150; i++) begin
         applyStimulus(randOperand(), randOperand(), $urandom_range(0, 3) == 0);
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule
